// File: rtl/seq_match_ctrl.sv
// Serial pattern-match controller: arms on start, shifts accepted bits through a history register,
// counts overlapping matches and pulses done at the target. Optional idle timeout: SEQ_MATCH_TIMEOUT_EN.
module seq_match_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TO_W  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
`ifdef SEQ_MATCH_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             done
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pattern;
    logic [CNT_W-1:0]   r_target;
    logic [PAT_W-1:0]   r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_match_pulse;
    logic               r_done;

    logic               w_accept;
    logic [PAT_W-1:0]   w_hist_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_match;
    logic               w_hit_target;

    assign w_accept     = bit_valid && (r_state == S_RUN);
    assign w_hist_next  = {r_hist[PAT_W-2:0], bit_in};
    assign w_fill_next  = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    // The fill guard stops a freshly cleared history from matching an all-zero pattern early.
    assign w_match      = w_accept && (w_hist_next == r_pattern) && (w_fill_next == FILL_W'(PAT_W));
    assign w_cnt_next   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_hit_target = (r_target != '0) && (w_cnt_next == r_target);

`ifdef SEQ_MATCH_TIMEOUT_EN
    logic [TO_W-1:0]    r_idle;
    logic               r_timeout;
    logic               w_idle_expire;

    // Expire on the edge where the idle count would land on all-ones.
    assign w_idle_expire = !w_accept && (r_idle == {{(TO_W-1){1'b1}}, 1'b0});
    assign timeout       = r_timeout;
`else
    logic               w_unused_to;
    assign w_unused_to = (TO_W > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pattern     <= '0;
            r_target      <= '0;
            r_hist        <= '0;
            r_fill        <= '0;
            r_cnt         <= '0;
            r_match_pulse <= 1'b0;
            r_done        <= 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
            r_idle        <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_match_pulse <= 1'b0;
            r_done        <= 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
            r_timeout     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_pattern <= cfg_pattern;
                        r_target  <= cfg_target;
                    end
                    if (start && !abort) begin
                        r_state <= S_RUN;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_cnt   <= '0;
`ifdef SEQ_MATCH_TIMEOUT_EN
                        r_idle  <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_hist <= w_hist_next;
                        r_fill <= w_fill_next;
                    end
                    if (w_match) begin
                        r_cnt         <= w_cnt_next;
                        r_match_pulse <= 1'b1;
                    end
`ifdef SEQ_MATCH_TIMEOUT_EN
                    r_idle <= w_accept ? '0 : r_idle + 1'b1;
`endif
                    // Abort wins over completion; the final match is still counted.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_match && w_hit_target) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
`ifdef SEQ_MATCH_TIMEOUT_EN
                    else if (w_idle_expire) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_ready   = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);
    assign match_pulse = r_match_pulse;
    assign match_cnt   = r_cnt;
    assign done        = r_done;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_seq_match_ctrl;

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int TO_W_TB = 4;
`else
    localparam int TO_W_TB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic       match_pulse;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
`ifdef SEQ_MATCH_TIMEOUT_EN
    logic       timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_match_ctrl #(.PAT_W(8), .CNT_W(8), .TO_W(TO_W_TB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt),
        .busy        (busy),
`ifdef SEQ_MATCH_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .done        (done)
    );

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       v;
        logic       b;
        logic       rdy;
        logic       mp;
        logic [7:0] cnt;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [7:0] pat, input logic [7:0] tgt,
                                input logic st, input logic ab, input logic v, input logic b,
                                input logic rdy, input logic mp, input logic [7:0] cnt,
                                input logic bsy, input logic dn);
        vec_t r;
        r.we = we; r.pat = pat; r.tgt = tgt; r.st = st; r.ab = ab; r.v = v; r.b = b;
        r.rdy = rdy; r.mp = mp; r.cnt = cnt; r.bsy = bsy; r.dn = dn;
        vecs.push_back(r);
    endfunction

    // Compare all status outputs against the expected tuple and print one line.
    task automatic check(input string tag, input int idx, input logic rdy, input logic mp,
                         input logic [7:0] cnt, input logic bsy, input logic dn);
        logic [11:0] act, exp;
        act = {bit_ready, match_pulse, match_cnt, busy, done};
        exp = {rdy, mp, cnt, bsy, dn};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got rdy=%b mp=%b cnt=%0d busy=%b done=%b, want rdy=%b mp=%b cnt=%0d busy=%b done=%b",
                     tag, idx, bit_ready, match_pulse, match_cnt, busy, done, rdy, mp, cnt, bsy, dn);
        end else begin
            $display("ok   %s[%0d]: rdy=%b mp=%b cnt=%0d busy=%b done=%b",
                     tag, idx, bit_ready, match_pulse, match_cnt, busy, done);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] pat, input logic [7:0] tgt,
                         input logic st, input logic ab, input logic v, input logic b);
        cfg_we = we; cfg_pattern = pat; cfg_target = tgt;
        start = st; abort = ab; bit_valid = v; bit_in = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d9;
        logic [7:0] bits;
        d9 = 8'hD9;

        // Test 1: single match of D9, target 1
        add(1, 8'hD9, 8'd1, 1, 0, 0, 0,  1, 0, 8'd0, 1, 0);
        bits = 8'hD9;
        for (int i = 7; i >= 1; i--) add(0, 0, 0, 0, 0, 1, bits[i],  1, 0, 8'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, bits[0],  0, 1, 8'd1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,        0, 0, 8'd1, 0, 0);
        // start together with abort stays in IDLE
        add(0, 0, 0, 1, 1, 0, 0,        0, 0, 8'd1, 0, 0);
        // Test 2: overlap, AA target 2, stream 1010101010
        add(1, 8'hAA, 8'd2, 1, 0, 0, 0, 1, 0, 8'd0, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 1, (i % 2 == 0),  1, 0, 8'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,  1, 1, 8'd1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1,  1, 0, 8'd1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,  0, 1, 8'd2, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 8'd2, 0, 0);
        // Test 3: fill guard with all-zero pattern, unlimited target
        add(1, 8'h00, 8'd0, 1, 0, 0, 0, 1, 0, 8'd0, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 1, 0,  1, 0, 8'd0, 1, 0);
        for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 1, 8'(i), 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,  0, 0, 8'd4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 8'd4, 0, 0);
        // cfg_we during RUN ignored; abort on the final-match edge
        add(1, 8'hD9, 8'd1, 1, 0, 0, 0, 1, 0, 8'd0, 1, 0);
        for (int i = 7; i >= 1; i--) add((i == 4), 8'hFF, 8'd5, 0, 0, 1, bits[i], 1, 0, 8'd0, 1, 0);
        add(0, 0, 0, 0, 1, 1, bits[0],  0, 1, 8'd1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,        0, 0, 8'd1, 0, 0);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 8'd0, 0, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].pat, vecs[i].tgt, vecs[i].st, vecs[i].ab, vecs[i].v, vecs[i].b);
            tick();
            check("vec", i, vecs[i].rdy, vecs[i].mp, vecs[i].cnt, vecs[i].bsy, vecs[i].dn);
        end

        // Test 4: valid 1-of-3 cycles; idle cycles carry inverted bits that must not shift in
        drive(1, 8'hD9, 8'd1, 1, 0, 0, 0);
        tick();
        check("tog_start", 0, 1, 0, 8'd0, 1, 0);
        for (int i = 7; i >= 0; i--) begin
            drive(0, 0, 0, 0, 0, 1, d9[i]);
            tick();
            check("tog_acc", 7 - i, (i != 0), (i == 0), (i == 0) ? 8'd1 : 8'd0, 1, (i == 0));
            if (i != 0) begin
                for (int k = 0; k < 2; k++) begin
                    drive(0, 0, 0, 0, 0, 0, ~d9[i]);
                    tick();
                    check("tog_gap", 7 - i, 1, 0, 8'd0, 1, 0);
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("tog_idle", 0, 0, 0, 8'd1, 0, 0);

        // Test 5: async reset mid-stream, then pattern register is back to 0
        drive(1, 8'hD9, 8'd0, 1, 0, 0, 0);
        tick();
        for (int i = 7; i >= 0; i--) begin
            drive(0, 0, 0, 0, 0, 1, d9[i]);
            tick();
        end
        check("rst_pre", 0, 1, 1, 8'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1'b1);
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 8'd0, 0, 0);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0);
        tick();
        check("rst_restart", 0, 1, 0, 8'd0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1'b0);
            tick();
            check("rst_fill", i, 1, (i == 7), (i == 7) ? 8'd1 : 8'd0, 1, 0);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        tick();
        check("rst_abort", 0, 0, 0, 8'd1, 0, 0);

`ifdef SEQ_MATCH_TIMEOUT_EN
        // Test 6: idle timeout after 15 edges without an accepted bit
        drive(1, 8'hD9, 8'd1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (timeout !== (i == 15) || busy !== (i != 15) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got to=%b busy=%b done=%b, want to=%b busy=%b done=0",
                         i, timeout, busy, done, (i == 15), (i != 15));
            end else begin
                $display("ok   timeout[%0d]: to=%b busy=%b", i, timeout, busy);
            end
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_end: got to=%b, want to=0", timeout);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
